qpu_exu_measure_histfile: RTL and testbench
===========================================

Name: qpu_exu_measure_histfile

Overview:
- Parametrised successor of the EXU measurement-result register.
- Keeps a per-qubit ring-buffer history of the last HIST_DEPTH results instead of a fixed two-entry ping-pong.
- Serves FMR-style masked reads of any history age with 1-cycle registered latency.
- Drives zero/one/equ fast-feedback flags to the event queue with same-cycle write bypass, and tracks per-qubit overflow.

Parameters:
- QUBIT_NUM, 12, number of qubits / result lanes.
- HIST_DEPTH, 4, history entries per qubit; power of two, >= 2.
- AGE_W, $clog2(HIST_DEPTH), width of the age selector and pointers.
- CNT_W, $clog2(HIST_DEPTH)+1, width of the per-qubit valid-entry counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mcu_measure_i_wen  in  1  measurement result return strobe.
- mcu_measure_i_data  in  QUBIT_NUM  returned result bits.
- oitf_ret_i_measurelist  in  QUBIT_NUM  qubits whose result is written on this return.
- clr_ena  in  1  history clear strobe.
- clr_list  in  QUBIT_NUM  qubits to clear.
- read_qubit_ena  in  1  FMR read request.
- read_qubit_list  in  QUBIT_NUM  read mask.
- read_hist_sel  in  AGE_W  age to read; 0 = newest.
- read_qubit_data  out  QUBIT_NUM  registered masked read data.
- read_qubit_valid  out  QUBIT_NUM  registered; lane holds an entry of the requested age.
- read_data_vld  out  1  1-cycle pulse, read outputs updated.
- qubit_measure_zero  out  QUBIT_NUM  newest result is 0 (bypassed).
- qubit_measure_one  out  QUBIT_NUM  newest result is 1 (bypassed).
- qubit_measure_equ  out  QUBIT_NUM  newest two results equal (bypassed).
- qubit_measure_ovf  out  QUBIT_NUM  sticky: an unread-cleared entry was overwritten.
- ovf_clr  in  1  clears all ovf bits.

Behaviour:
- Per-qubit state:
  - hist[k][HIST_DEPTH] result bits, no reset.
  - wptr[k] (AGE_W), reset 0.
  - cnt[k] (CNT_W), reset 0, saturates at HIST_DEPTH.
  - ovf[k], reset 0.
- Write: wen_k = mcu_measure_i_wen & oitf_ret_i_measurelist[k].
  - Store hist[k][wptr] <= data[k].
  - wptr <= wptr+1, wrapping mod HIST_DEPTH.
  - cnt <= min(cnt+1, HIST_DEPTH).
  - If cnt == HIST_DEPTH before the write, set ovf[k] (oldest entry overwritten).
- Clear: clr_ena & clr_list[k] sets cnt=0 and wptr=0; ovf is unchanged.
- Clear + write to the same lane in the same cycle: clear first, then write.
  - Result: hist[k][0]=data, wptr=1, cnt=1, no ovf set.
- ovf_clr clears all ovf bits. If ovf_clr and an ovf-setting write occur in the same cycle, the set wins.
- Newest entry is hist[wptr-1]; the entry of age a is hist[wptr-1-a], all mod HIST_DEPTH.
- Read (1-cycle latency):
  - On the cycle after read_qubit_ena: read_data_vld=1.
  - read_qubit_valid[k] = list[k] & (cnt > sel).
  - read_qubit_data[k] = read_qubit_valid[k] & hist_age(sel).
  - Outputs hold until the next read.
  - Read samples pre-write state; a same-cycle write is not visible.
  - Reset values: read_qubit_data=0, read_qubit_valid=0, read_data_vld=0.
- Feedback (combinational, bypassed):
  - new_k = wen_k ? data[k] : hist newest.
  - one[k] = (cnt>0 | wen_k) & new_k.
  - zero[k] = (cnt>0 | wen_k) & ~new_k.
  - With no entry, both zero and one are 0.
  - equ[k] = 1 only when two entries exist (effective cnt >= 2, counting a bypassed write) and the newest two are equal. When bypassing, the pair is data vs stored newest.
- After reset: all flags 0, ovf=0, read outputs 0.
- Reset mid-read: the pending read_data_vld is dropped.
- A clear in the same cycle as a read does not affect that read's data (pre-clear state is sampled).

Optional Feature:
- Macro QPU_MEASURE_PARITY_EN.
- When defined: adds output read_parity (1 bit), registered with the read = XOR of read_qubit_data across all lanes, reset 0. Used for syndrome-parity feedback.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then write q0 = 1,0,1 on three returns -> cnt=3. Read with sel=0/1/2 gives data[0]=1/0/1, valid[0]=1. Read with sel=3 gives valid[0]=0, data[0]=0, 1 cycle after ena.
- HIST_DEPTH=4: five writes to q2 (1,1,0,0,1) -> ovf[2]=1 after the 5th. Age 3 = 1 (second write); the first write is lost. ovf_clr -> ovf[2]=0.
- Stored q1 newest=0, cnt=1; write 0 to q1 -> same cycle zero[1]=1, equ[1]=1. Write 1 next -> one[1]=1, equ[1]=0.
- After reset: zero=one=equ=0 on all lanes. A single write of 1 to q3 -> one[3]=1, equ[3]=0.
- Same cycle clr_list[4]=1 and write q4=1 -> next: cnt=1, newest=1. Read sel=1 gives valid[4]=0.
- With QPU_MEASURE_PARITY_EN: q0=1, q1=1, q2=1 newest; read list=0b111 -> read_parity=1. List=0b011 -> read_parity=0.

Source files
------------

// File: rtl/qpu_exu_measure_histfile_if.sv
// ---------------------------------------------------------------------------
// qpu_exu_measure_histfile_if
// Bundles the measurement-history signals: result returns from the MCU,
// history clears, FMR-style masked reads and the fast-feedback flags.
//   master : drives returns, clears, read requests and ovf_clr; receives
//            read results and feedback flags.
//   slave  : the history file itself.
// Optional: QPU_MEASURE_PARITY_EN adds read_parity (XOR of the read data).
// ---------------------------------------------------------------------------
interface qpu_exu_measure_histfile_if #(
  parameter int QUBIT_NUM = 12,
  parameter int AGE_W     = 2
);
  logic                 mcu_measure_i_wen;
  logic [QUBIT_NUM-1:0] mcu_measure_i_data;
  logic [QUBIT_NUM-1:0] oitf_ret_i_measurelist;
  logic                 clr_ena;
  logic [QUBIT_NUM-1:0] clr_list;
  logic                 read_qubit_ena;
  logic [QUBIT_NUM-1:0] read_qubit_list;
  logic [AGE_W-1:0]     read_hist_sel;
  logic [QUBIT_NUM-1:0] read_qubit_data;
  logic [QUBIT_NUM-1:0] read_qubit_valid;
  logic                 read_data_vld;
  logic [QUBIT_NUM-1:0] qubit_measure_zero;
  logic [QUBIT_NUM-1:0] qubit_measure_one;
  logic [QUBIT_NUM-1:0] qubit_measure_equ;
  logic [QUBIT_NUM-1:0] qubit_measure_ovf;
  logic                 ovf_clr;
`ifdef QPU_MEASURE_PARITY_EN
  logic                 read_parity;
`endif

  modport master (
    output mcu_measure_i_wen, mcu_measure_i_data, oitf_ret_i_measurelist,
    output clr_ena, clr_list, read_qubit_ena, read_qubit_list, read_hist_sel,
    output ovf_clr,
    input  read_qubit_data, read_qubit_valid, read_data_vld,
    input  qubit_measure_zero, qubit_measure_one, qubit_measure_equ,
    input  qubit_measure_ovf
`ifdef QPU_MEASURE_PARITY_EN
    , input read_parity
`endif
  );

  modport slave (
    input  mcu_measure_i_wen, mcu_measure_i_data, oitf_ret_i_measurelist,
    input  clr_ena, clr_list, read_qubit_ena, read_qubit_list, read_hist_sel,
    input  ovf_clr,
    output read_qubit_data, read_qubit_valid, read_data_vld,
    output qubit_measure_zero, qubit_measure_one, qubit_measure_equ,
    output qubit_measure_ovf
`ifdef QPU_MEASURE_PARITY_EN
    , output read_parity
`endif
  );
endinterface

// File: rtl/qpu_exu_measure_histfile.sv
// ---------------------------------------------------------------------------
// qpu_exu_measure_histfile
// Per-qubit ring-buffer history of the last HIST_DEPTH measurement results.
//   clk, rst : clock and synchronous active-high reset.
//   hist_if  : slave side of qpu_exu_measure_histfile_if
//              - result returns (wen/data/measurelist) append to the ring
//              - clr_ena/clr_list empty a lane's history
//              - read_* : masked read of any age, registered 1-cycle latency
//              - qubit_measure_zero/one/equ : feedback flags, write-bypassed
//              - qubit_measure_ovf : sticky overwrite flag, ovf_clr clears
// Optional: define QPU_MEASURE_PARITY_EN to add read_parity, the XOR of the
// registered read data across all lanes.
// ---------------------------------------------------------------------------
module qpu_exu_measure_histfile #(
  parameter int QUBIT_NUM  = 12,
  parameter int HIST_DEPTH = 4,
  parameter int AGE_W      = $clog2(HIST_DEPTH),
  parameter int CNT_W      = $clog2(HIST_DEPTH) + 1
) (
  input logic                       clk,
  input logic                       rst,
  qpu_exu_measure_histfile_if.slave hist_if
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(HIST_DEPTH);

  logic [HIST_DEPTH-1:0] hist_q [QUBIT_NUM];
  logic [HIST_DEPTH-1:0] hist_d [QUBIT_NUM];
  logic [AGE_W-1:0]      wptr_q [QUBIT_NUM];
  logic [AGE_W-1:0]      wptr_d [QUBIT_NUM];
  logic [CNT_W-1:0]      cnt_q  [QUBIT_NUM];
  logic [CNT_W-1:0]      cnt_d  [QUBIT_NUM];
  logic [QUBIT_NUM-1:0]  ovf_q, ovf_d;
  logic [QUBIT_NUM-1:0]  rdData_q, rdData_d;
  logic [QUBIT_NUM-1:0]  rdValid_q, rdValid_d;
  logic                  rdVld_q, rdVld_d;
  logic [QUBIT_NUM-1:0]  fbZero, fbOne, fbEqu;

  // Next history state. A clear on the same lane as a write is applied
  // first, so the write lands in slot 0 of an empty ring and never counts
  // as an overwrite.
  always_comb begin : p_next
    logic laneWen;
    logic laneClr;
    logic ovfSet;
    for (int k = 0; k < QUBIT_NUM; k++) begin
      laneWen   = hist_if.mcu_measure_i_wen & hist_if.oitf_ret_i_measurelist[k];
      laneClr   = hist_if.clr_ena & hist_if.clr_list[k];
      hist_d[k] = hist_q[k];
      wptr_d[k] = laneClr ? '0 : wptr_q[k];
      cnt_d[k]  = laneClr ? '0 : cnt_q[k];
      ovfSet    = 1'b0;
      if (laneWen) begin
        hist_d[k][wptr_d[k]] = hist_if.mcu_measure_i_data[k];
        ovfSet               = (cnt_d[k] == CNT_FULL);
        if (cnt_d[k] != CNT_FULL) cnt_d[k] = cnt_d[k] + CNT_W'(1);
        wptr_d[k] = wptr_d[k] + AGE_W'(1);
      end
      // Set beats a simultaneous ovf_clr.
      ovf_d[k] = ovfSet | (ovf_q[k] & ~hist_if.ovf_clr);
    end
  end

  // Read path samples the pre-write, pre-clear state. Age a lives at
  // wptr-1-a; the subtraction wraps naturally since HIST_DEPTH is 2^AGE_W.
  always_comb begin : p_read
    logic [AGE_W-1:0] ageIdx;
    logic             laneValid;
    rdVld_d   = hist_if.read_qubit_ena;
    rdData_d  = rdData_q;
    rdValid_d = rdValid_q;
    ageIdx    = '0;
    laneValid = 1'b0;
    if (hist_if.read_qubit_ena) begin
      for (int k = 0; k < QUBIT_NUM; k++) begin
        ageIdx       = wptr_q[k] - AGE_W'(1) - hist_if.read_hist_sel;
        laneValid    = hist_if.read_qubit_list[k] &
                       (cnt_q[k] > {1'b0, hist_if.read_hist_sel});
        rdValid_d[k] = laneValid;
        rdData_d[k]  = laneValid & hist_q[k][ageIdx];
      end
    end
  end

  // Feedback flags: a write in flight replaces the newest entry, and the
  // stored newest then becomes the second entry for the equality check.
  always_comb begin : p_feedback
    logic [AGE_W-1:0] newIdx;
    logic [AGE_W-1:0] prevIdx;
    logic             laneWen;
    logic             newest;
    logic             newBit;
    logic             live;
    fbZero  = '0;
    fbOne   = '0;
    fbEqu   = '0;
    newIdx  = '0;
    prevIdx = '0;
    laneWen = 1'b0;
    newest  = 1'b0;
    newBit  = 1'b0;
    live    = 1'b0;
    for (int k = 0; k < QUBIT_NUM; k++) begin
      laneWen   = hist_if.mcu_measure_i_wen & hist_if.oitf_ret_i_measurelist[k];
      newIdx    = wptr_q[k] - AGE_W'(1);
      prevIdx   = wptr_q[k] - AGE_W'(2);
      newest    = hist_q[k][newIdx];
      newBit    = laneWen ? hist_if.mcu_measure_i_data[k] : newest;
      live      = (cnt_q[k] != '0) | laneWen;
      fbOne[k]  = live & newBit;
      fbZero[k] = live & ~newBit;
      if (laneWen)
        fbEqu[k] = (cnt_q[k] != '0) & (hist_if.mcu_measure_i_data[k] == newest);
      else
        fbEqu[k] = (cnt_q[k] >= CNT_W'(2)) & (newest == hist_q[k][prevIdx]);
    end
  end

  // History bits carry no reset; cnt alone decides which are meaningful.
  always_ff @(posedge clk) begin
    hist_q <= hist_d;
  end

  // Control state and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < QUBIT_NUM; k++) begin
        wptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      ovf_q     <= '0;
      rdData_q  <= '0;
      rdValid_q <= '0;
      rdVld_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rdData_q  <= rdData_d;
      rdValid_q <= rdValid_d;
      rdVld_q   <= rdVld_d;
    end
  end

`ifdef QPU_MEASURE_PARITY_EN
  logic rdParity_q;

  // Parity follows the read data register, updating only on a read.
  always_ff @(posedge clk) begin
    if (rst)                         rdParity_q <= 1'b0;
    else if (hist_if.read_qubit_ena) rdParity_q <= ^rdData_d;
  end

  assign hist_if.read_parity = rdParity_q;
`endif

  assign hist_if.read_qubit_data    = rdData_q;
  assign hist_if.read_qubit_valid   = rdValid_q;
  assign hist_if.read_data_vld      = rdVld_q;
  assign hist_if.qubit_measure_zero = fbZero;
  assign hist_if.qubit_measure_one  = fbOne;
  assign hist_if.qubit_measure_equ  = fbEqu;
  assign hist_if.qubit_measure_ovf  = ovf_q;

endmodule

// File: tb/tb_qpu_exu_measure_histfile.sv
// ---------------------------------------------------------------------------
// tb_qpu_exu_measure_histfile
// Drives the history file through directed scenarios followed by random
// traffic. Expected values come from a newest-first list model of each
// qubit's history held in the bench.
// ---------------------------------------------------------------------------
module tb_qpu_exu_measure_histfile;

  localparam int QN = 12;
  localparam int HD = 4;
  localparam int AW = $clog2(HD);

  logic clk = 1'b0;
  logic rst;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  qpu_exu_measure_histfile_if #(.QUBIT_NUM(QN), .AGE_W(AW)) bus ();

  qpu_exu_measure_histfile #(.QUBIT_NUM(QN), .HIST_DEPTH(HD)) dut (
    .clk     (clk),
    .rst     (rst),
    .hist_if (bus)
  );

  // Reference model: hm[k][a] is the result of age a (0 = newest).
  bit          hm [QN][HD];
  int          mc [QN];
  logic [QN-1:0] mOvf;
  logic [QN-1:0] eData, eValid;
  logic          eVld;
  logic          eParity;

  int tests = 0;
  int fails = 0;

  function automatic logic [QN-1:0] lane(input int k);
    return QN'(1) << k;
  endfunction

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [QN-1:0] obs,
                             input logic [QN-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkRegistered();
    checkOutput("read_data_vld", QN'(bus.read_data_vld), QN'(eVld));
    checkOutput("read_qubit_data", bus.read_qubit_data, eData);
    checkOutput("read_qubit_valid", bus.read_qubit_valid, eValid);
    checkOutput("qubit_measure_ovf", bus.qubit_measure_ovf, mOvf);
`ifdef QPU_MEASURE_PARITY_EN
    checkOutput("read_parity", QN'(bus.read_parity), QN'(eParity));
`endif
  endtask

  // One clock cycle of stimulus: flags checked before the edge, the model
  // advanced, then registered outputs checked after the edge.
  task automatic applyStimulus(input logic wen, input logic [QN-1:0] wlist,
                               input logic [QN-1:0] wdata, input logic clr,
                               input logic [QN-1:0] clist, input logic rd,
                               input logic [QN-1:0] rlist,
                               input logic [AW-1:0] sel, input logic oclr);
    logic [QN-1:0] ez, eo, ee;
    @(negedge clk);
    bus.mcu_measure_i_wen      = wen;
    bus.oitf_ret_i_measurelist = wlist;
    bus.mcu_measure_i_data     = wdata;
    bus.clr_ena                = clr;
    bus.clr_list               = clist;
    bus.read_qubit_ena         = rd;
    bus.read_qubit_list        = rlist;
    bus.read_hist_sel          = sel;
    bus.ovf_clr                = oclr;
    #1;
    for (int k = 0; k < QN; k++) begin
      bit lw, nb, live;
      lw    = wen && wlist[k];
      nb    = lw ? wdata[k] : hm[k][0];
      live  = (mc[k] > 0) || lw;
      eo[k] = live && nb;
      ez[k] = live && !nb;
      ee[k] = lw ? ((mc[k] >= 1) && (wdata[k] == hm[k][0]))
                 : ((mc[k] >= 2) && (hm[k][0] == hm[k][1]));
    end
    checkOutput("qubit_measure_zero", bus.qubit_measure_zero, ez);
    checkOutput("qubit_measure_one", bus.qubit_measure_one, eo);
    checkOutput("qubit_measure_equ", bus.qubit_measure_equ, ee);

    if (rd) begin
      eVld = 1'b1;
      for (int k = 0; k < QN; k++) begin
        eValid[k] = rlist[k] && (mc[k] > int'(sel));
        eData[k]  = eValid[k] && hm[k][sel];
      end
      eParity = ^eData;
    end else begin
      eVld = 1'b0;
    end

    if (oclr) mOvf = '0;
    for (int k = 0; k < QN; k++) begin
      if (clr && clist[k]) mc[k] = 0;
      if (wen && wlist[k]) begin
        if (mc[k] == HD) mOvf[k] = 1'b1;
        for (int j = HD - 1; j > 0; j--) hm[k][j] = hm[k][j-1];
        hm[k][0] = wdata[k];
        if (mc[k] < HD) mc[k]++;
      end
    end

    @(posedge clk);
    #1;
    checkRegistered();
  endtask

  task automatic idleInputs();
    bus.mcu_measure_i_wen      = 1'b0;
    bus.oitf_ret_i_measurelist = '0;
    bus.mcu_measure_i_data     = '0;
    bus.clr_ena                = 1'b0;
    bus.clr_list               = '0;
    bus.read_qubit_ena         = 1'b0;
    bus.read_qubit_list        = '0;
    bus.read_hist_sel          = '0;
    bus.ovf_clr                = 1'b0;
  endtask

  // Reset for one edge; with rdDuring a read request collides with reset.
  task automatic doReset(input logic rdDuring);
    @(negedge clk);
    idleInputs();
    rst                 = 1'b1;
    bus.read_qubit_ena  = rdDuring;
    bus.read_qubit_list = '1;
    @(posedge clk);
    #1;
    for (int k = 0; k < QN; k++) mc[k] = 0;
    mOvf    = '0;
    eData   = '0;
    eValid  = '0;
    eVld    = 1'b0;
    eParity = 1'b0;
    checkRegistered();
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    #1;
    checkOutput("reset_zero", bus.qubit_measure_zero, '0);
    checkOutput("reset_one", bus.qubit_measure_one, '0);
    checkOutput("reset_equ", bus.qubit_measure_equ, '0);
  endtask

  task automatic writeLanes(input logic [QN-1:0] wlist, input logic [QN-1:0] wdata);
    applyStimulus(1'b1, wlist, wdata, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic readLanes(input logic [QN-1:0] rlist, input logic [AW-1:0] sel);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, rlist, sel, 1'b0);
  endtask

  initial begin
    logic [3:0] planData;
    logic [3:0] planValid;
    logic [4:0] q2Seq;
    rst = 1'b1;
    idleInputs();
    doReset(1'b0);

    // q0 receives 1,0,1; ages 0..3 read back 1,0,1 and then nothing.
    writeLanes(lane(0), lane(0));
    writeLanes(lane(0), '0);
    writeLanes(lane(0), lane(0));
    planData  = 4'b0101;
    planValid = 4'b0111;
    for (int s = 0; s < HD; s++) begin
      readLanes(lane(0), AW'(s));
      checkOutput("plan_q0_data", QN'(bus.read_qubit_data[0]), QN'(planData[s]));
      checkOutput("plan_q0_valid", QN'(bus.read_qubit_valid[0]), QN'(planValid[s]));
    end

    // q2 receives five results; the fifth overwrites the first.
    q2Seq = 5'b10011;
    for (int i = 0; i < 5; i++) writeLanes(lane(2), q2Seq[i] ? lane(2) : '0);
    checkOutput("plan_q2_ovf", QN'(bus.qubit_measure_ovf[2]), QN'(1));
    readLanes(lane(2), AW'(3));
    checkOutput("plan_q2_age3", QN'(bus.read_qubit_data[2]), QN'(1));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("plan_q2_ovf_clr", QN'(bus.qubit_measure_ovf[2]), QN'(0));

    // Bypassed feedback on q1: 0 then 0 then 1.
    doReset(1'b0);
    writeLanes(lane(1), '0);
    writeLanes(lane(1), '0);
    writeLanes(lane(1), lane(1));
    writeLanes(lane(3), lane(3));

    // q4 gets history, then a clear and a write together.
    writeLanes(lane(4), '0);
    writeLanes(lane(4), '0);
    applyStimulus(1'b1, lane(4), lane(4), 1'b1, lane(4), 1'b0, '0, '0, 1'b0);
    readLanes(lane(4), AW'(0));
    checkOutput("plan_q4_newest", QN'(bus.read_qubit_data[4]), QN'(1));
    readLanes(lane(4), AW'(1));
    checkOutput("plan_q4_age1_valid", QN'(bus.read_qubit_valid[4]), QN'(0));

    // Read colliding with a clear and a write on the same lane.
    applyStimulus(1'b1, lane(4), '0, 1'b1, lane(4), 1'b1, lane(4), AW'(0), 1'b0);

    // q0..q2 newest 1 for the parity case.
    writeLanes(QN'(3'b111), QN'(3'b111));
    readLanes(QN'(3'b111), AW'(0));
`ifdef QPU_MEASURE_PARITY_EN
    checkOutput("plan_parity_111", QN'(bus.read_parity), QN'(1));
`endif
    readLanes(QN'(3'b011), AW'(0));
`ifdef QPU_MEASURE_PARITY_EN
    checkOutput("plan_parity_011", QN'(bus.read_parity), QN'(0));
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, QN'($urandom), QN'($urandom),
                    $urandom_range(0, 7) == 0, QN'($urandom),
                    $urandom_range(0, 1) == 1, QN'($urandom), AW'($urandom),
                    $urandom_range(0, 15) == 0);
    end

    // Reset arriving together with a read request.
    doReset(1'b1);
    readLanes('1, AW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
